// File: rtl/noise_sampler.sv
// noise_sampler: samples the LFSR word every hold period and scales it by a signed level.
// Define NOISE_LPF_EN to add a one-pole low-pass stage on the output.
module noise_sampler #(
    parameter int HOLD_W    = 16,
    parameter int LPF_SHIFT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       rnd,
    output logic              rnd_step,
    input  logic [HOLD_W-1:0] hold,
    input  logic [11:0]       level,
    output logic [15:0]       sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SCALE,
`ifdef NOISE_LPF_EN
        FILT,
`endif
        PRESENT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HOLD_W-1:0] cnt;
    logic              tick;
    logic [15:0]       x;
    logic signed [27:0] x_ext;
    logic signed [27:0] l_ext;
    logic signed [27:0] p;
    logic signed [16:0] p_sh;
    logic [15:0]       s_sat;
    logic [15:0]       sample_q;
    logic              unused_bits;

    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt <= (hold == '0) ? '0 : hold - HOLD_W'(1);
            end else begin
                cnt <= cnt - HOLD_W'(1);
            end
        end
    end

    // A tick is only absorbed in IDLE or by an accepting PRESENT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (!enable) begin
            overrun <= 1'b0;
        end else if (tick && (state != IDLE) &&
                     !((state == PRESENT) && sample_ready)) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rnd_step     = 1'b0;
        sample_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                rnd_step  = 1'b1;
                state_nxt = SCALE;
            end
            SCALE: begin
`ifdef NOISE_LPF_EN
                state_nxt = FILT;
`else
                state_nxt = PRESENT;
`endif
            end
`ifdef NOISE_LPF_EN
            FILT: begin
                state_nxt = PRESENT;
            end
`endif
            PRESENT: begin
                sample_valid = 1'b1;
                if (sample_ready) state_nxt = tick ? CAPTURE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= '0;
        end else if (state == CAPTURE) begin
            x <= rnd[31:16];
        end
    end

    // Q1.11 level: drop 11 fraction bits, then clamp to 16 bits.
    assign x_ext = 28'($signed(x));
    assign l_ext = 28'($signed(level));
    assign p     = x_ext * l_ext;
    assign p_sh  = p[27:11];

    always_comb begin
        s_sat = p_sh[15:0];
        if (p_sh[16] != p_sh[15]) begin
            s_sat = p_sh[16] ? 16'h8000 : 16'h7FFF;
        end
    end

`ifdef NOISE_LPF_EN
    logic [15:0]        s_q;
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] y_nxt;

    // sample_q doubles as the filter state y.
    assign diff  = $signed({s_q[15], s_q}) - $signed({sample_q[15], sample_q});
    assign step  = diff >>> LPF_SHIFT;
    assign y_nxt = $signed({sample_q[15], sample_q}) + step;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_q      <= '0;
            sample_q <= '0;
        end else begin
            if (state == SCALE) s_q <= s_sat;
            if (state == FILT) sample_q <= y_nxt[15:0];
        end
    end

    assign unused_bits = ^{rnd[15:0], p[10:0], y_nxt[16]};
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_q <= '0;
        end else if (state == SCALE) begin
            sample_q <= s_sat;
        end
    end

    assign unused_bits = ^{rnd[15:0], p[10:0], 1'(LPF_SHIFT)};
`endif

    assign sample = sample_q;

endmodule

// File: tb/tb_noise_sampler.sv
// tb_noise_sampler: directed and random stimulus for noise_sampler,
// checked each cycle against a transaction-timeline reference model.
module tb_noise_sampler;

    localparam int HW = 16;
    localparam int SH = 3;
`ifdef NOISE_LPF_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [31:0]   rnd;
    logic          rnd_step;
    logic [HW-1:0] hold;
    logic [11:0]   level;
    logic [15:0]   sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;

    always #5 clk = ~clk;

    noise_sampler #(.HOLD_W(HW), .LPF_SHIFT(SH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rnd          (rnd),
        .rnd_step     (rnd_step),
        .hold         (hold),
        .level        (level),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n_fail = 0;
    int pulses = 0;

    // Model: m_since = cycles since the accepted tick (-1 when idle,
    // 1 = capture cycle, LAT = presenting).
    int          m_since;
    int          m_cnt;
    int          m_ovr;
    int          m_s;
    int          m_y;
    logic [15:0] m_x;
    logic [15:0] m_sample;

    function automatic int scale(input logic [15:0] xv, input logic [11:0] lv);
        int p;
        int s;
        p = int'($signed(xv)) * int'($signed(lv));
        s = p >>> 11;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_since  = -1;
        m_cnt    = 0;
        m_ovr    = 0;
        m_s      = 0;
        m_y      = 0;
        m_x      = '0;
        m_sample = '0;
    endtask

    task automatic cycle();
        logic tick;
        @(negedge clk);
        chk("rnd_step", 32'(rnd_step), 32'(m_since == 1));
        chk("valid", 32'(sample_valid), 32'(m_since == LAT));
        chk("sample", 32'(sample), 32'(m_sample));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (rnd_step === 1'b1) pulses++;
        tick = enable && (m_cnt == 0);
        if (!reset) begin
            model_reset();
        end else begin
            if (m_since == 1) m_x = rnd[31:16];
            if (m_since == 2) begin
                m_s = scale(m_x, level);
                if (LAT == 3) m_sample = 16'(m_s);
            end
            if (LAT == 4 && m_since == 3) begin
                m_y      = m_y + ((m_s - m_y) >>> SH);
                m_sample = 16'(m_y);
            end
            if (!enable) m_ovr = 0;
            else if (tick && m_since != -1 && !(m_since == LAT && sample_ready)) m_ovr = 1;
            if (m_since == -1) begin
                if (tick) m_since = 1;
            end else if (m_since == LAT) begin
                if (sample_ready) m_since = tick ? 1 : -1;
            end else begin
                m_since++;
            end
            if (enable) begin
                if (tick) m_cnt = (hold == '0) ? 0 : int'(hold) - 1;
                else m_cnt = m_cnt - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        reset        = 1'b0;
        enable       = 1'b0;
        rnd          = '0;
        hold         = 16'd4;
        level        = '0;
        sample_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        cycle();

`ifdef NOISE_LPF_EN
        reset        = 1'b1;
        enable       = 1'b1;
        hold         = 16'd4;
        level        = 12'h400;
        rnd          = 32'h1000_0000;
        sample_ready = 1'b1;
        repeat (5) cycle();
        chk("lpf_first", 32'(sample), 32'h0100);
        repeat (4) cycle();
        chk("lpf_second", 32'(sample), 32'h01E0);
        reset  = 1'b0;
        enable = 1'b0;
        cycle();
`endif

        reset        = 1'b1;
        enable       = 1'b1;
        hold         = 16'd4;
        level        = 12'h400;
        rnd          = 32'h4000_1234;
        sample_ready = 1'b1;
        pulses       = 0;
        repeat (16) cycle();
        chk("pulses_per_4", 32'(pulses), 32'd4);
        chk("basic_overrun", 32'(overrun), 32'd0);
`ifndef NOISE_LPF_EN
        chk("basic_2000", 32'(sample), 32'h2000);
`endif

        level = 12'h800;
        rnd   = 32'h8000_0000;
        repeat (8) cycle();
`ifndef NOISE_LPF_EN
        chk("sat_pos", 32'(sample), 32'h7FFF);
`endif
        level = 12'h7FF;
        repeat (8) cycle();
`ifndef NOISE_LPF_EN
        chk("sat_neg", 32'(sample), 32'h8010);
`endif

        sample_ready = 1'b0;
        pulses       = 0;
        repeat (12) cycle();
        chk("bp_pulses", 32'(pulses), 32'd1);
        chk("bp_overrun", 32'(overrun), 32'd1);
        chk("bp_valid", 32'(sample_valid), 32'd1);
        enable = 1'b0;
        cycle();
        chk("ovr_clear", 32'(overrun), 32'd0);
        chk("hold_valid", 32'(sample_valid), 32'd1);

        enable       = 1'b1;
        hold         = 16'(LAT);
        sample_ready = 1'b1;
        pulses       = 0;
        repeat (15) cycle();
        chk("b2b_pulses", 32'(pulses), 32'(13 / LAT + 1));
        chk("b2b_overrun", 32'(overrun), 32'd0);

        hold = 16'd5;
        k    = 0;
        while (m_since != 2 && k < 12) begin
            cycle();
            k++;
        end
        reset = 1'b0;
        cycle();
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_step", 32'(rnd_step), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        repeat (10) cycle();

        repeat (400) begin
            reset        = ($urandom_range(0, 49) != 0);
            enable       = ($urandom_range(0, 9) != 0);
            hold         = 16'($urandom_range(0, 6));
            level        = 12'($urandom);
            rnd          = $urandom;
            sample_ready = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/noise_sampler.md
# noise_sampler

Downstream consumer of the 32-bit LFSR word generator. It samples the LFSR output at a programmable hold period, steps the LFSR once per sample, and scales the sample by a signed 12-bit level. The result is presented as a signed audio-rate noise sample over a valid/ready handshake to the mixer path. An optional one-pole low-pass stage can be compiled in to colour the noise.

## Interface
- HOLD_W, 16, width of the hold-period input and counter
- LPF_SHIFT, 3, low-pass coefficient shift (used only with NOISE_LPF_EN)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset; one clock domain
- enable  in  1  runs the hold counter; low freezes the counter and clears overrun
- rnd  in  32  current LFSR word
- rnd_step  out  1  one-cycle pulse advancing the LFSR (drives LFSR enable)
- hold  in  HOLD_W  sample period in clk cycles; 0 is treated as 1
- level  in  12  signed amplitude, Q1.11
- sample  out  16  signed scaled (optionally filtered) noise sample
- sample_valid  out  1  sample is held and valid
- sample_ready  in  1  consumer accepts when high together with sample_valid
- overrun  out  1  sticky: a tick was dropped

## Operation
- Hold counter `cnt` (HOLD_W bits, reset 0):
  - When `enable` is high and `cnt`==0: internal `tick`=1 and `cnt` <= max(hold,1)-1.
  - Otherwise, while `enable` is high, `cnt` decrements.
  - Tick period is max(hold,1) cycles.
- FSM states: IDLE, CAPTURE, SCALE, [FILT], PRESENT. Reset state is IDLE.
  - IDLE: on `tick` -> CAPTURE.
  - CAPTURE: `rnd_step`=1; capture `x` <= rnd[31:16] (signed). Next state SCALE.
  - SCALE: `p` = x*level (28-bit signed); `s` = p>>>11, saturated to [-32768, 32767]. Register into `sample`, or into the filter input when filtered. Next state PRESENT, or FILT when filtered.
  - FILT (only with NOISE_LPF_EN): y <= y + ((s - y)>>>LPF_SHIFT). Difference is 17-bit signed; y is 16-bit, reset 0. sample <= new y. Next state PRESENT.
  - PRESENT: `sample_valid`=1 and `sample` stable. On sample_valid&sample_ready: -> CAPTURE if `tick` is high in the same cycle, else -> IDLE.
- `rnd_step` is a pure decode of state==CAPTURE: exactly one pulse per produced sample.
- Overrun: `tick` in any state other than IDLE, and not in PRESENT with sample_ready=1, sets `overrun` <= 1 and the tick is dropped.
  - `overrun` is cleared only by reset or by enable=0.
- enable=0 stops new ticks. An in-flight sample still completes and is held in PRESENT.
- Reset values:
  - sample=0, sample_valid=0, rnd_step=0, overrun=0.
  - FSM=IDLE, cnt=0, filter y=0.
- Reset mid-operation discards any in-flight or presented sample. The next output requires a fresh tick.

## Timing
- Tick in cycle t: CAPTURE in t+1 (rnd_step high), SCALE in t+2, sample_valid high from t+3.
  - With NOISE_LPF_EN: FILT in t+3, sample_valid high from t+4.
- Handshake completes on the edge where sample_valid&sample_ready=1. sample_valid drops the next cycle unless a simultaneous tick forces back-to-back production, in which case it re-asserts 3 (4) cycles later.
- Minimum hold without overrun while ready is held high: 3 (4 with filter).
- `rnd` is sampled only at the end of the CAPTURE cycle. The LFSR advances on that same edge, so the next capture sees a fresh word.

## Configuration
- NOISE_LPF_EN defined:
  - FILT state and the y register are present.
  - sample = filtered value.
  - Latency +1 cycle.
- NOISE_LPF_EN undefined:
  - No FILT state and no y register.
  - sample = saturated scaled value.
  - LPF_SHIFT is ignored.

## Test plan
- hold=4, level=12'h400, rnd=32'h4000_1234, sample_ready=1 -> sample=16'h2000. sample_valid is high 3 cycles after the tick, one rnd_step pulse per 4 cycles, overrun=0.
- Saturation:
  - rnd[31:16]=16'h8000, level=12'h800 -> sample=16'h7FFF.
  - rnd[31:16]=16'h8000, level=12'h7FF -> sample=16'h8010.
- Backpressure: hold=4, sample_ready=0 for 12 cycles -> sample_valid stays high and sample is constant. Exactly one rnd_step pulse. overrun=1 after the next tick, and stays 1 until enable=0.
- Back-to-back: hold=3, sample_ready=1 -> the accept and the tick coincide. FSM goes PRESENT->CAPTURE with no IDLE cycle, overrun stays 0, samples arrive every 3 cycles.
- Reset: reset=0 asserted during SCALE -> next cycle sample=0, sample_valid=0, rnd_step=0, overrun=0. After release, the first sample_valid comes 3 cycles after the first tick.
- NOISE_LPF_EN, LPF_SHIFT=3, rnd[31:16]=16'h1000, level=12'h400 (s=16'h0800) -> first sample=16'h0100, second sample=16'h01E0.
